// File: rtl/hrm_pkg.sv
// rtl/hrm_pkg.sv - shared defaults and occupancy state encoding for the CPU inbox
package hrm_pkg;

   localparam int HRM_WIDTH = 8;

   typedef enum logic [1:0] {
      EMPTY   = 2'b00,
      PARTIAL = 2'b01,
      FULL    = 2'b10
   } hrm_state_t;

endpackage

// File: rtl/hrm_inbox_mem.sv
// rtl/hrm_inbox_mem.sv - inbox word storage: registered write port, asynchronous read port
module hrm_inbox_mem
   import hrm_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = HRM_WIDTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   // Storage is deliberately not reset; occupancy logic decides what is valid.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hrm_inbox.sv
// rtl/hrm_inbox.sv - CPU inbox FIFO (producer stream in, rIn/inEmpty drain); HRM_INBOX_STATS_EN adds rd_total
module hrm_inbox
   import hrm_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = HRM_WIDTH,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             rIn,
   output logic [WIDTH-1:0] inData,
   output logic             inEmpty,
   output logic [AW:0]      count,
   output logic             udf
`ifdef HRM_INBOX_STATS_EN
   ,
   output logic [15:0]      rd_total
`endif
);

   localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   hrm_state_t      state_q, state_d;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     cnt_q;
   logic            udf_q;
   logic            live_q;
   logic            accept, take, underrun;

   // live_q is low on the first edge after reset release so that edge never moves data.
   assign accept   = live_q && s_valid && (state_q != FULL);
   assign take     = live_q && rIn && (state_q != EMPTY);
   assign underrun = live_q && rIn && (state_q == EMPTY);

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (accept) state_d = PARTIAL;
         end
         PARTIAL: begin
            if (accept && !take && cnt_q == CNT_LAST)
               state_d = FULL;
            else if (take && !accept && cnt_q == CNT_ONE)
               state_d = EMPTY;
         end
         FULL: begin
            if (take) state_d = PARTIAL;
         end
         default: state_d = EMPTY;
      endcase
      if (i_clr) state_d = EMPTY;
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= EMPTY;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         cnt_q   <= '0;
         udf_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         live_q  <= 1'b1;
         state_q <= state_d;
         if (i_clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            udf_q  <= 1'b0;
         end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (take)   rd_ptr <= rd_ptr + 1'b1;
            case ({accept, take})
               2'b10:   cnt_q <= cnt_q + 1'b1;
               2'b01:   cnt_q <= cnt_q - 1'b1;
               default: cnt_q <= cnt_q;
            endcase
            if (underrun) udf_q <= 1'b1;
         end
      end
   end

   hrm_inbox_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (accept && !i_clr),
      .waddr (wr_ptr),
      .wdata (s_data),
      .raddr (rd_ptr),
      .rdata (inData)
   );

   assign s_ready = (state_q != FULL);
   assign inEmpty = (state_q == EMPTY);
   assign count   = cnt_q;
   assign udf     = udf_q;

`ifdef HRM_INBOX_STATS_EN
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)   rd_total <= '0;
      else if (i_clr) rd_total <= '0;
      else if (take)  rd_total <= rd_total + 1'b1;
   end
`endif

endmodule

// File: tb/tb_hrm_inbox.sv
// tb/tb_hrm_inbox.sv - self-checking bench for hrm_inbox against a queue model
module tb_hrm_inbox;

   localparam int DEPTH = 8;
   localparam int WIDTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             i_rst_n, i_clr, s_valid, rIn;
   logic [WIDTH-1:0] s_data;
   logic             s_ready, inEmpty, udf;
   logic [WIDTH-1:0] inData;
   logic [CW-1:0]    count;
`ifdef HRM_INBOX_STATS_EN
   logic [15:0]      rd_total;
`endif

   always #5 clk = ~clk;

   hrm_inbox #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk      (clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (i_clr),
      .s_data   (s_data),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .rIn      (rIn),
      .inData   (inData),
      .inEmpty  (inEmpty),
      .count    (count),
      .udf      (udf)
`ifdef HRM_INBOX_STATS_EN
      ,
      .rd_total (rd_total)
`endif
   );

   logic [WIDTH-1:0] mq[$];
   bit               m_udf;
   bit               m_live;
   int               m_total;
   int               n_vec;
   int               n_bad;

   function automatic logic [CW+2:0] exp_flags();
      exp_flags = {mq.size() == 0, mq.size() < DEPTH, CW'(mq.size()), m_udf};
   endfunction

   // Applies one cycle of inputs, advances the model, and returns at the following negedge.
   task automatic tick(input bit sv, input logic [WIDTH-1:0] sd, input bit ri, input bit clr);
      bit had_room;
      bit was_empty;
      s_valid = sv; s_data = sd; rIn = ri; i_clr = clr;
      had_room  = mq.size() < DEPTH;
      was_empty = mq.size() == 0;
      if (clr) begin
         mq.delete(); m_udf = 0; m_total = 0;
      end else if (m_live) begin
         if (ri && was_empty) m_udf = 1;
         if (ri && !was_empty) begin
            void'(mq.pop_front());
            m_total++;
         end
         if (sv && had_room) mq.push_back(sd);
      end
      m_live = 1;
      @(posedge clk);
      @(negedge clk);
      s_valid = 0; rIn = 0; i_clr = 0;
   endtask

   task automatic test_reset();
      i_rst_n = 0; i_clr = 0; s_valid = 0; rIn = 0; s_data = '0;
      mq.delete(); m_udf = 0; m_total = 0; m_live = 0;
      #1;
      n_vec++;
      if ({inEmpty, s_ready, count, udf} !== {1'b1, 1'b1, CW'(0), 1'b0}) begin
         n_bad++;
         $display("FAIL reset_state: got %h want %h", {inEmpty, s_ready, count, udf}, {1'b1, 1'b1, CW'(0), 1'b0});
      end
      repeat (3) @(negedge clk);
      i_rst_n = 1;
      tick(1, 8'h11, 0, 0);
      n_vec++;
      if ({inEmpty, s_ready, count, udf} !== exp_flags()) begin
         n_bad++;
         $display("FAIL reset_release_edge: got %h want %h", {inEmpty, s_ready, count, udf}, exp_flags());
      end
   endtask

   task automatic test_order();
      logic [WIDTH-1:0] words [3];
      words[0] = 8'h05; words[1] = 8'h07; words[2] = 8'h09;
      tick(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick(1, words[i], 0, 0);
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (inEmpty !== 1'b0 || inData !== words[k] || mq[0] !== words[k]) begin
            n_bad++;
            $display("FAIL order_head[%0d]: got empty=%b data=%h want empty=0 data=%h", k, inEmpty, inData, words[k]);
         end
         tick(0, 0, 1, 0);
         tick(0, 0, 0, 0);
         tick(0, 0, 0, 0);
      end
      n_vec++;
      if ({inEmpty, s_ready, count, udf} !== {1'b1, 1'b1, CW'(0), 1'b0}) begin
         n_bad++;
         $display("FAIL order_drained: got %h want %h", {inEmpty, s_ready, count, udf}, {1'b1, 1'b1, CW'(0), 1'b0});
      end
   endtask

   task automatic test_full();
      tick(0, 0, 0, 1);
      for (int i = 0; i < 9; i++) tick(1, 8'h10 + 8'(i), 0, 0);
      n_vec++;
      if (count !== CW'(DEPTH) || s_ready !== 1'b0 || {inEmpty, s_ready, count, udf} !== exp_flags()) begin
         n_bad++;
         $display("FAIL full_stop: got count=%0d ready=%b want count=%0d ready=0", count, s_ready, DEPTH);
      end
      tick(1, 8'h18, 1, 0);
      n_vec++;
      if (count !== CW'(DEPTH - 1) || s_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL full_pop_only: got count=%0d ready=%b want count=%0d ready=1", count, s_ready, DEPTH - 1);
      end
      tick(1, 8'h18, 0, 0);
      n_vec++;
      if (count !== CW'(DEPTH) || s_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL full_refill: got count=%0d ready=%b want count=%0d ready=0", count, s_ready, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_vec++;
         if (inData !== 8'h11 + 8'(i)) begin
            n_bad++;
            $display("FAIL full_drain[%0d]: got %h want %h", i, inData, 8'h11 + 8'(i));
         end
         tick(0, 0, 1, 0);
      end
   endtask

   task automatic test_back_to_back();
      tick(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) tick(1, 8'($urandom), 0, 0);
      for (int c = 0; c < 20; c++) begin
         n_vec++;
         if (inData !== mq[0] || count !== CW'(4)) begin
            n_bad++;
            $display("FAIL b2b[%0d]: got data=%h count=%0d want data=%h count=4", c, inData, count, mq[0]);
         end
         tick(1, 8'($urandom), 1, 0);
      end
      while (mq.size() > 0) begin
         n_vec++;
         if (inData !== mq[0]) begin
            n_bad++;
            $display("FAIL b2b_drain: got %h want %h", inData, mq[0]);
         end
         tick(0, 0, 1, 0);
      end
   endtask

   task automatic test_underflow();
      tick(0, 0, 0, 1);
      tick(0, 0, 1, 0);
      tick(0, 0, 0, 0);
      n_vec++;
      if (udf !== 1'b1 || count !== CW'(0) || inEmpty !== 1'b1) begin
         n_bad++;
         $display("FAIL udf_set: got udf=%b count=%0d empty=%b want udf=1 count=0 empty=1", udf, count, inEmpty);
      end
      tick(1, 8'h3C, 1, 0);
      n_vec++;
      if (udf !== 1'b1 || count !== CW'(1) || inData !== 8'h3C) begin
         n_bad++;
         $display("FAIL udf_push_in_empty: got udf=%b count=%0d data=%h want udf=1 count=1 data=3c", udf, count, inData);
      end
      tick(1, 8'h44, 1, 1);
      n_vec++;
      if (udf !== 1'b0 || count !== CW'(0) || inEmpty !== 1'b1) begin
         n_bad++;
         $display("FAIL udf_clear: got udf=%b count=%0d empty=%b want udf=0 count=0 empty=1", udf, count, inEmpty);
      end
   endtask

   task automatic test_reset_mid();
      tick(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick(1, 8'h60 + 8'(i), 0, 0);
      @(posedge clk);
      #1 i_rst_n = 0;
      #1;
      mq.delete(); m_udf = 0; m_total = 0; m_live = 0;
      n_vec++;
      if ({inEmpty, s_ready, count, udf} !== {1'b1, 1'b1, CW'(0), 1'b0}) begin
         n_bad++;
         $display("FAIL rst_mid_immediate: got %h want %h", {inEmpty, s_ready, count, udf}, {1'b1, 1'b1, CW'(0), 1'b0});
      end
      @(negedge clk);
      i_rst_n = 1;
      tick(1, 8'hAA, 1, 0);
      n_vec++;
      if ({inEmpty, s_ready, count, udf} !== {1'b1, 1'b1, CW'(0), 1'b0}) begin
         n_bad++;
         $display("FAIL rst_release_idle: got %h want %h", {inEmpty, s_ready, count, udf}, {1'b1, 1'b1, CW'(0), 1'b0});
      end
      tick(1, 8'hBB, 0, 0);
      n_vec++;
      if (count !== CW'(1) || inData !== 8'hBB) begin
         n_bad++;
         $display("FAIL rst_first_push: got count=%0d data=%h want count=1 data=bb", count, inData);
      end
   endtask

   task automatic test_random();
      tick(0, 0, 0, 1);
      for (int c = 0; c < 400; c++) begin
         tick($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 9) < 5, $urandom_range(0, 39) == 0);
         n_vec++;
         if ({inEmpty, s_ready, count, udf} !== exp_flags() || (mq.size() > 0 && inData !== mq[0])) begin
            n_bad++;
            $display("FAIL random[%0d]: got flags=%h data=%h want flags=%h data=%h", c,
                     {inEmpty, s_ready, count, udf}, inData, exp_flags(), (mq.size() > 0) ? mq[0] : inData);
         end
`ifdef HRM_INBOX_STATS_EN
         n_vec++;
         if (rd_total !== 16'(m_total)) begin
            n_bad++;
            $display("FAIL random_rd_total[%0d]: got %0d want %0d", c, rd_total, 16'(m_total));
         end
`endif
      end
   endtask

`ifdef HRM_INBOX_STATS_EN
   task automatic test_stats();
      tick(0, 0, 0, 1);
      tick(1, 8'($urandom), 0, 0);
      for (int c = 0; c < 70000; c++) tick(1, 8'($urandom), 1, 0);
      n_vec++;
      if (rd_total !== 16'(m_total) || rd_total !== 16'd4464) begin
         n_bad++;
         $display("FAIL stats_wrap: got %0d want %0d", rd_total, 16'(m_total));
      end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_bad = 0;
      test_reset();
      test_order();
      test_full();
      test_back_to_back();
      test_underflow();
      test_reset_mid();
      test_random();
`ifdef HRM_INBOX_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
